// File: rtl/piradip_mts_pkg.sv
// piradip_mts_pkg: shared defaults and helpers for the MTS clocking block.
//   DEF_* : default values for the synchroniser depth, divider ratios,
//           lock threshold and SYSREF stop timeout.
//   cnt_w : bit width needed to count 0..n-1 (n below 2 is treated as 2).
package piradip_mts_pkg;

  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_ADC_DIV      = 2;
  localparam int DEF_DAC_DIV      = 5;
  localparam int DEF_LOCK_COUNT   = 3;
  localparam int DEF_STOP_TIMEOUT = 64;

  function automatic int cnt_w(input int n);
    return $clog2((n < 2) ? 2 : n);
  endfunction

endpackage

// File: rtl/piradip_mts_clk_div.sv
// piradip_mts_clk_div: SYSREF-alignable clock divider (one per tile type).
// The counter is held at 0 with the clock low until rel_i, then free-runs
// 0..DIV-1. zero_i restarts the count at 0 on the next cycle.
// Ports:
//   pl_clk, reset : fabric clock, synchronous active-high reset
//   rel_i         : release the held divider (one-cycle pulse)
//   zero_i        : force the counter to 0 next cycle (realignment)
//   clk_o         : divided clock, high while cnt < DIV/2
//   last_o        : counter sits at DIV-1, i.e. it wraps on this edge
//   run_o         : divider has been released
module piradip_mts_clk_div
  import piradip_mts_pkg::*;
#(
  parameter int DIV = DEF_ADC_DIV
) (
  input  logic pl_clk,
  input  logic reset,
  input  logic rel_i,
  input  logic zero_i,
  output logic clk_o,
  output logic last_o,
  output logic run_o
);

  localparam int W = cnt_w(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  localparam logic [W-1:0] HIGH = W'(DIV / 2);

  logic [W-1:0] cnt_q, cnt_d;
  logic         run_q, run_d;

  always_comb begin
    run_d = run_q | rel_i;
    cnt_d = cnt_q;
    // Still held: a release lands the counter on 0, so held state is 0 too.
    if (!run_q)                        cnt_d = '0;
    else if (zero_i || cnt_q == LAST)  cnt_d = '0;
    else                               cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge pl_clk) begin
    if (reset) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
    end
  end

  // Gate with run_q: a held counter is 0, which would otherwise read as high.
  assign clk_o  = run_q && (cnt_q < HIGH);
  assign last_o = run_q && (cnt_q == LAST);
  assign run_o  = run_q;

endmodule

// File: rtl/piradip_mts_clocking.sv
// piradip_mts_clocking: multi-tile-sync SYSREF conditioning on pl_clk.
// Synchronises sysref_in, re-issues it to ADC/DAC tiles, runs ADC/DAC
// dividers phase-aligned to SYSREF rising edges, and reports lock/stop.
// Optional: PIRADIP_MTS_SYSREF_GATE_EN gates sysref_adc/dac with locked.
// Ports:
//   pl_clk, reset        : clock, synchronous active-high reset
//   sysref_in            : asynchronous SYSREF
//   sysref_adc/dac       : re-timed SYSREF (SYNC_STAGES+1 cycles latency)
//   adc_clk / dac_clk    : pl_clk/ADC_DIV, pl_clk/DAC_DIV
//   locked               : LOCK_COUNT consecutive aligned SYSREF edges seen
//   clk_in_stopped       : no SYSREF edge for STOP_TIMEOUT cycles
//   clk_fb_stopped       : dividers not yet released since reset
module piradip_mts_clocking
  import piradip_mts_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int ADC_DIV      = DEF_ADC_DIV,
  parameter int DAC_DIV      = DEF_DAC_DIV,
  parameter int LOCK_COUNT   = DEF_LOCK_COUNT,
  parameter int STOP_TIMEOUT = DEF_STOP_TIMEOUT
) (
  input  logic pl_clk,
  input  logic reset,
  input  logic sysref_in,
  output logic sysref_adc,
  output logic sysref_dac,
  output logic adc_clk,
  output logic dac_clk,
  output logic locked,
  output logic clk_in_stopped,
  output logic clk_fb_stopped
);

  localparam int GW = cnt_w(LOCK_COUNT + 1);
  localparam int IW = cnt_w(STOP_TIMEOUT + 1);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COUNT);
  localparam logic [IW-1:0] IDLE_MAX = IW'(STOP_TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_d_q, s_d_d;
  logic [GW-1:0]          good_q, good_d;
  logic [IW-1:0]          idle_q, idle_d;
  logic                   locked_q, locked_d;
  logic                   stop_q, stop_d;

  logic s_sync, e, released, aligned, rel, realign;
  logic run_adc, run_dac, last_adc, last_dac;

  assign s_sync   = sync_q[SYNC_STAGES-1];
  assign e        = s_sync & ~s_d_q;
  assign released = run_adc & run_dac;
  // Both counters on their last count: the SYSREF edge coincides with wrap.
  assign aligned  = last_adc & last_dac;
  assign rel      = e & ~released;
  assign realign  = e & released & ~aligned;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sysref_in};
    s_d_d  = s_sync;

    idle_d = e ? '0 : ((idle_q == IDLE_MAX) ? idle_q : idle_q + IW'(1));
    stop_d = (idle_d == IDLE_MAX);

    // The releasing edge is not counted. A SYSREF edge is scored before the
    // stop clear so the edge that ends a stop period already counts.
    good_d = good_q;
    if (e && released)
      good_d = !aligned ? '0 : ((good_q == GOOD_MAX) ? good_q : good_q + GW'(1));
    else if (stop_d)
      good_d = '0;

    locked_d = (good_d == GOOD_MAX) && !stop_d;
  end

  always_ff @(posedge pl_clk) begin
    if (reset) begin
      sync_q   <= '0;
      s_d_q    <= 1'b0;
      good_q   <= '0;
      idle_q   <= '0;
      locked_q <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      s_d_q    <= s_d_d;
      good_q   <= good_d;
      idle_q   <= idle_d;
      locked_q <= locked_d;
      stop_q   <= stop_d;
    end
  end

  piradip_mts_clk_div #(.DIV(ADC_DIV)) u_adc_div (
    .pl_clk (pl_clk),
    .reset  (reset),
    .rel_i  (rel),
    .zero_i (realign),
    .clk_o  (adc_clk),
    .last_o (last_adc),
    .run_o  (run_adc)
  );

  piradip_mts_clk_div #(.DIV(DAC_DIV)) u_dac_div (
    .pl_clk (pl_clk),
    .reset  (reset),
    .rel_i  (rel),
    .zero_i (realign),
    .clk_o  (dac_clk),
    .last_o (last_dac),
    .run_o  (run_dac)
  );

`ifdef PIRADIP_MTS_SYSREF_GATE_EN
  assign sysref_adc = s_d_q & locked_q;
  assign sysref_dac = s_d_q & locked_q;
`else
  assign sysref_adc = s_d_q;
  assign sysref_dac = s_d_q;
`endif

  assign locked         = locked_q;
  assign clk_in_stopped = stop_q;
  assign clk_fb_stopped = ~released;

endmodule

// File: tb/tb_piradip_mts_clocking.sv
// Directed bench: a scripted sysref_in waveform (period 10 cycles, one late
// edge, a stop window, a one-cycle reset pulse) checked against a table of
// hand-computed outputs at selected cycles, plus a few sequence checks.
module tb_piradip_mts_clocking;

  logic pl_clk = 1'b0;
  logic reset, sysref_in;
  logic sysref_adc, sysref_dac, adc_clk, dac_clk, locked;
  logic clk_in_stopped, clk_fb_stopped;

  piradip_mts_clocking dut (
    .pl_clk         (pl_clk),
    .reset          (reset),
    .sysref_in      (sysref_in),
    .sysref_adc     (sysref_adc),
    .sysref_dac     (sysref_dac),
    .adc_clk        (adc_clk),
    .dac_clk        (dac_clk),
    .locked         (locked),
    .clk_in_stopped (clk_in_stopped),
    .clk_fb_stopped (clk_fb_stopped)
  );

  always #5 pl_clk = ~pl_clk;

  typedef struct {
    int   cyc;
    logic sref, adc, dac, lk, stp, fb;
  } vec_t;

  vec_t tbl[$];
  int   n_run = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int cyc, input logic act, input logic exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic add(input int c, input logic [5:0] v);
    vec_t t;
    t.cyc = c;
    {t.sref, t.adc, t.dac, t.lk, t.stp, t.fb} = v;
    tbl.push_back(t);
  endtask

  // sysref_in per cycle: 100 ns period, rising edge at 50 delayed to 53,
  // held low over 105..179, normal again from 180.
  function automatic logic f(input int c);
    if (c >= 105 && c < 180) return 1'b0;
    if (c >= 50 && c < 60)   return (c == 53 || c == 54);
    return (c % 10) < 5;
  endfunction

  initial begin
    int   adc_hi, dac_hi;
    logic adc_prev;
    adc_hi = 0; dac_hi = 0; adc_prev = 1'b0;

    // Outputs after the pl_clk edge ending cycle c: {sref,adc,dac,lk,stp,fb}
    add(0,   6'b000001); add(1,   6'b000001);
    add(2,   6'b111000); add(3,   6'b101000); add(4,   6'b110000);
    add(7,   6'b001000); add(11,  6'b000000);
    add(31,  6'b000000); add(32,  6'b111100); add(33,  6'b101100);
    add(54,  6'b010100); add(55,  6'b111000); add(56,  6'b101000);
    add(62,  6'b111000); add(91,  6'b000000); add(92,  6'b111100);
    add(165, 6'b000100); add(166, 6'b010010);
    add(181, 6'b000010); add(182, 6'b111000);
    add(202, 6'b111100); add(206, 6'b000001); add(211, 6'b000001);
    add(212, 6'b111000); add(241, 6'b000000); add(242, 6'b111100);

    // Reset with sysref_in toggled high: must be ignored.
    reset = 1'b1; sysref_in = 1'b0;
    repeat (10) @(posedge pl_clk);
    #1 sysref_in = 1'b1;
    repeat (10) @(posedge pl_clk);
    #1;
    chk("rst_sysref_adc", -1, sysref_adc, 1'b0);
    chk("rst_sysref_dac", -1, sysref_dac, 1'b0);
    chk("rst_adc_clk",    -1, adc_clk,    1'b0);
    chk("rst_dac_clk",    -1, dac_clk,    1'b0);
    chk("rst_locked",     -1, locked,     1'b0);
    chk("rst_in_stopped", -1, clk_in_stopped, 1'b0);
    chk("rst_fb_stopped", -1, clk_fb_stopped, 1'b1);

    for (int c = 0; c <= 250; c++) begin
      reset     = (c == 206);
      sysref_in = f(c);
      @(posedge pl_clk);
      #1;
      foreach (tbl[i]) begin
        if (tbl[i].cyc == c) begin
          logic es;
          es = tbl[i].sref;
`ifdef PIRADIP_MTS_SYSREF_GATE_EN
          es = es & tbl[i].lk;
`endif
          chk("sysref_adc",     c, sysref_adc,     es);
          chk("sysref_dac",     c, sysref_dac,     es);
          chk("adc_clk",        c, adc_clk,        tbl[i].adc);
          chk("dac_clk",        c, dac_clk,        tbl[i].dac);
          chk("locked",         c, locked,         tbl[i].lk);
          chk("clk_in_stopped", c, clk_in_stopped, tbl[i].stp);
          chk("clk_fb_stopped", c, clk_fb_stopped, tbl[i].fb);
        end
      end
      // Duty over one 10-cycle window: ADC 1-of-2 high, DAC 2-of-5 high.
      if (c >= 112 && c <= 121) begin
        adc_hi += int'(adc_clk);
        dac_hi += int'(dac_clk);
      end
      if (c == 121) begin
        chk("adc_high_cycles", c, adc_hi == 5, 1'b1);
        chk("dac_high_cycles", c, dac_hi == 4, 1'b1);
      end
      // Divider keeps running while SYSREF is stopped.
      if (c == 166) adc_prev = adc_clk;
      if (c == 167) chk("adc_toggles_when_stopped", c, adc_clk, ~adc_prev);
      if (c >= 167 && c <= 181)
        chk("in_stopped_held", c, clk_in_stopped, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
